ex_muldiv: RTL and testbench

Multi-cycle multiply/divide unit beside the EX-stage ALU, producing the 2·DATA_W {HI, LO} result for MULT/MULTU/DIV/DIVU and, optionally, multiply-accumulate ops. The EX stage starts an operation and stalls the pipeline via `stall_req_o` until `done_o`. The EX stage's HI/LO write path then commits `hi_o`/`lo_o` on the `done_o` cycle. Width and multiplier latency are parameters.

---
 rtl/muldiv_pkg.sv | 32 +++
 rtl/div_iter.sv | 37 +++
 rtl/ex_muldiv.sv | 189 ++++++++++++++++++
 tb/tb_ex_muldiv.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the EX-stage multiply/divide unit.
package muldiv_pkg;

    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_MADD  = 4'd4,
        OP_MADDU = 4'd5,
        OP_MSUB  = 4'd6,
        OP_MSUBU = 4'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

    function automatic logic is_signed(input muldiv_op_e op);
        return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
    endfunction

    function automatic logic is_accum(input muldiv_op_e op);
        return op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    endfunction

endpackage

// File: rtl/div_iter.sv
// Radix-2 restoring divider core on unsigned magnitudes; the load cycle
// already performs the first quotient step, each step cycle adds one more.
module div_iter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    logic [DATA_W-1:0] rem_src, quo_src, div_src, div_q;
    logic [DATA_W:0]   partial, diff;

    assign rem_src = load ? '0 : remainder;
    assign quo_src = load ? dividend : quotient;
    assign div_src = load ? divisor : div_q;

    // The running remainder is always below the divisor, so the shifted
    // partial fits in DATA_W+1 bits and the borrow is diff's top bit.
    assign partial = {rem_src, quo_src[DATA_W-1]};
    assign diff    = partial - {1'b0, div_src};

    // NOTE: pure datapath registers carry no reset; the FSM decides when they are meaningful.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (load | step) begin
            div_q     <= div_src;
            quotient  <= {quo_src[DATA_W-2:0], ~diff[DATA_W]};
            remainder <= diff[DATA_W] ? partial[DATA_W-1:0] : diff[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle multiply/divide unit beside the EX-stage ALU.
// Define MULDIV_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulate ops.
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int MUL_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  muldiv_op_e        op_i,
    input  logic [DATA_W-1:0] reg1_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic              annul_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              div_by_zero_o,
    output logic              stall_req_o
);

    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);

    muldiv_state_e       state;
    logic [CNT_W-1:0]    cnt;
    logic                legal, accept, op_div, divisor_zero, op_signed;
    logic                neg_q, neg_r, div_load, div_step;
    logic [2*DATA_W-1:0] a_ext, b_ext, prod_now, prod_last, mul_result;
    logic [DATA_W-1:0]   dividend_mag, divisor_mag, quotient, remainder;

`ifdef MULDIV_MADD_EN
    assign legal = (op_i <= OP_MSUBU);
`else
    assign legal = (op_i <= OP_DIVU);
`endif

    assign accept       = start_i & ~busy_o & ~annul_i & legal;
    assign stall_req_o  = (start_i & accept) | (busy_o & ~done_o);
    assign op_div       = op_i inside {OP_DIV, OP_DIVU};
    assign divisor_zero = (reg2_i == '0);
    assign op_signed    = is_signed(op_i);

    // Sign-extending to 2*DATA_W makes the low half of one unsigned product
    // correct for both signed and unsigned operands.
    assign a_ext    = op_signed ? {{DATA_W{reg1_i[DATA_W-1]}}, reg1_i} : {{DATA_W{1'b0}}, reg1_i};
    assign b_ext    = op_signed ? {{DATA_W{reg2_i[DATA_W-1]}}, reg2_i} : {{DATA_W{1'b0}}, reg2_i};
    assign prod_now = a_ext * b_ext;

    generate
        if (MUL_LAT == 1) begin : g_mul_comb
            assign prod_last = prod_now;
        end else begin : g_mul_pipe
            logic [2*DATA_W-1:0] line [MUL_LAT-1];
            always_ff @(posedge clk) begin
                line[0] <= prod_now;
                for (int i = 1; i < MUL_LAT - 1; i++) line[i] <= line[i-1];
            end
            assign prod_last = line[MUL_LAT-2];
        end
    endgenerate

`ifdef MULDIV_MADD_EN
    logic [2*DATA_W-1:0] acc_q, acc_src;
    logic                accum_q, sub_q, accum_src, sub_src;

    always_ff @(posedge clk) begin
        if (accept) begin
            acc_q   <= {hi_i, lo_i};
            accum_q <= is_accum(op_i);
            sub_q   <= op_i inside {OP_MSUB, OP_MSUBU};
        end
    end

    assign acc_src   = (MUL_LAT == 1) ? {hi_i, lo_i} : acc_q;
    assign accum_src = (MUL_LAT == 1) ? is_accum(op_i) : accum_q;
    assign sub_src   = (MUL_LAT == 1) ? (op_i inside {OP_MSUB, OP_MSUBU}) : sub_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        mul_result = prod_last;
        if (accum_src) mul_result = sub_src ? acc_src - prod_last : acc_src + prod_last;
    end
`else
    logic unused_acc;
    assign unused_acc = ^{hi_i, lo_i};
    assign mul_result = prod_last;
`endif

    assign dividend_mag = (op_signed & reg1_i[DATA_W-1]) ? -reg1_i : reg1_i;
    assign divisor_mag  = (op_signed & reg2_i[DATA_W-1]) ? -reg2_i : reg2_i;
    assign div_load     = accept & op_div & ~divisor_zero;
    assign div_step     = (state == ST_DIV) && (cnt != DIV_LAST);

    div_iter #(.DATA_W(DATA_W)) u_div_iter (
        .clk       (clk),
        .load      (div_load),
        .step      (div_step),
        .dividend  (dividend_mag),
        .divisor   (divisor_mag),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            hi_o          <= '0;
            lo_o          <= '0;
            div_by_zero_o <= 1'b0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cnt    <= '0;
                        busy_o <= 1'b1;
                        if (op_div) begin
                            neg_q <= op_signed & (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
                            neg_r <= op_signed & reg1_i[DATA_W-1];
                            if (divisor_zero) begin
                                state         <= ST_DONE;
                                done_o        <= 1'b1;
                                hi_o          <= reg1_i;
                                lo_o          <= '1;
                                div_by_zero_o <= 1'b1;
                            end else begin
                                state <= ST_DIV;
                            end
                        end else if (MUL_LAT == 1) begin
                            state          <= ST_DONE;
                            done_o         <= 1'b1;
                            {hi_o, lo_o}   <= mul_result;
                            div_by_zero_o  <= 1'b0;
                        end else begin
                            state <= ST_MUL;
                        end
                    end
                end
                ST_MUL: begin
                    if (annul_i) begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end else if (cnt == MUL_LAST) begin
                        state         <= ST_DONE;
                        done_o        <= 1'b1;
                        {hi_o, lo_o}  <= mul_result;
                        div_by_zero_o <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DIV: begin
                    if (annul_i) begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end else if (cnt == DIV_LAST) begin
                        state         <= ST_DONE;
                        done_o        <= 1'b1;
                        lo_o          <= neg_q ? -quotient : quotient;
                        hi_o          <= neg_r ? -remainder : remainder;
                        div_by_zero_o <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv (DATA_W=32, MUL_LAT=2).
module tb_ex_muldiv;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start_i, annul_i;
    muldiv_op_e  op_i;
    logic [31:0] reg1_i, reg2_i, hi_i, lo_i;
    logic        busy_o, done_o, div_by_zero_o, stall_req_o;
    logic [31:0] hi_o, lo_o;

    int n_tests = 0;
    int n_fail  = 0;

    ex_muldiv #(.DATA_W(32), .MUL_LAT(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .op_i          (op_i),
        .reg1_i        (reg1_i),
        .reg2_i        (reg2_i),
        .hi_i          (hi_i),
        .lo_i          (lo_i),
        .annul_i       (annul_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o),
        .div_by_zero_o (div_by_zero_o),
        .stall_req_o   (stall_req_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op in the current cycle and follow it to completion.
    task automatic run_op(input string tag, input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hin, input logic [31:0] lin, input int exp_lat,
                          input logic [63:0] exp_res, input logic exp_dbz);
        int lat;
        op_i = op; reg1_i = a; reg2_i = b; hi_i = hin; lo_i = lin; start_i = 1'b1;
        #1;
        check({tag, ".stall_accept"}, stall_req_o, 1);
        tick();
        start_i = 1'b0;
        lat = 1;
        check({tag, ".busy"}, busy_o, 1);
        check({tag, ".stall_busy"}, stall_req_o, (exp_lat > 1));
        while (!done_o && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".hilo"}, {hi_o, lo_o}, exp_res);
        check({tag, ".dbz"}, div_by_zero_o, exp_dbz);
        tick();
        check({tag, ".idle_after"}, {busy_o, done_o}, 2'b00);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; op_i = OP_MULT;
        reg1_i = '0; reg2_i = '0; hi_i = '0; lo_i = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("reset.busy", busy_o, 0);
        check("reset.done", done_o, 0);
        check("reset.hilo", {hi_o, lo_o}, 64'h0);
        check("reset.dbz", div_by_zero_o, 0);
        check("reset.stall", stall_req_o, 0);
        tick();

        run_op("mult", OP_MULT, 32'hFFFF_FFFF, 32'h2, 0, 0, 2, 64'hFFFF_FFFF_FFFF_FFFE, 0);

        // MULTU with a competing start held high while busy.
        op_i = OP_MULTU; reg1_i = 32'hFFFF_FFFF; reg2_i = 32'h2; start_i = 1'b1;
        tick();
        op_i = OP_DIVU; reg2_i = 32'h0;
        check("multu.busy", busy_o, 1);
        tick();
        start_i = 1'b0;
        check("multu.done", done_o, 1);
        check("multu.hilo", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFE);
        tick();
        check("multu.start_ignored", {busy_o, done_o}, 2'b00);

        run_op("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'h2, 0, 0, 33, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 33, 64'h0000_0000_8000_0000, 0);
        run_op("div_7_neg2", OP_DIV, 32'h7, 32'hFFFF_FFFE, 0, 0, 33, 64'h0000_0001_FFFF_FFFD, 0);
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 0, 0, 33, 64'h0000_0002_0000_000E, 0);
        run_op("divu_by0", OP_DIVU, 32'd100, 32'd0, 0, 0, 1, 64'h0000_0064_FFFF_FFFF, 1);

        // Annul a divide at N+10; results from the previous op must survive.
        op_i = OP_DIV; reg1_i = 32'd1000; reg2_i = 32'd3; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        seen = 0;
        for (int i = 1; i < 10; i++) begin
            if (done_o) seen = 1;
            tick();
        end
        annul_i = 1'b1;
        #1;
        check("annul.no_done_before", seen | done_o, 0);
        tick();
        annul_i = 1'b0;
        check("annul.idle", {busy_o, done_o}, 2'b00);
        check("annul.hilo_kept", {hi_o, lo_o}, 64'h0000_0064_FFFF_FFFF);
        check("annul.dbz_kept", div_by_zero_o, 1);
        run_op("multu_3x5", OP_MULTU, 32'd3, 32'd5, 0, 0, 2, 64'd15, 0);

        // start together with annul: nothing accepted.
        op_i = OP_MULT; reg1_i = 32'd2; reg2_i = 32'd2; start_i = 1'b1; annul_i = 1'b1;
        #1;
        check("start_annul.stall", stall_req_o, 0);
        tick();
        start_i = 1'b0; annul_i = 1'b0;
        check("start_annul.busy", busy_o, 0);

        // Illegal encoding never accepted.
        op_i = muldiv_op_e'(4'hF); start_i = 1'b1;
        #1;
        check("illegal.stall", stall_req_o, 0);
        tick();
        start_i = 1'b0;
        check("illegal.busy", busy_o, 0);

`ifdef MULDIV_MADD_EN
        run_op("maddu", OP_MADDU, 32'd1, 32'd1, 32'h0, 32'hFFFF_FFFF, 2, 64'h0000_0001_0000_0000, 0);
        run_op("msub", OP_MSUB, 32'd1, 32'd1, 32'h0, 32'h0, 2, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op("madd_neg", OP_MADD, 32'hFFFF_FFFD, 32'd4, 32'h0, 32'd10, 2, 64'hFFFF_FFFF_FFFF_FFFE, 0);
`else
        op_i = OP_MADD; reg1_i = 32'd1; reg2_i = 32'd1; start_i = 1'b1;
        #1;
        check("madd_off.stall", stall_req_o, 0);
        tick();
        start_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy_o | done_o) seen = 1;
            tick();
        end
        check("madd_off.never_accepted", seen, 0);
`endif

        // Reset during a divide: everything back to reset values.
        op_i = OP_DIVU; reg1_i = 32'd500; reg2_i = 32'd9; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 1; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid.busy_done", {busy_o, done_o}, 2'b00);
        check("rst_mid.hilo", {hi_o, lo_o}, 64'h0);
        check("rst_mid.dbz", div_by_zero_o, 0);
        tick();
        check("rst_mid.stays_idle", {busy_o, done_o}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
